lwe_mac_datapath: RTL

- Arithmetic stage directly downstream of the op controller.
- Consumes the per-element enable, opcode, row index and output address stream, plus the 1-cycle-latency operand SRAM read data.
- Performs LWE inner-product encrypt/decrypt (mod q, q = 2^CIPHERTEXT_WIDTH) and elementwise ciphertext add.
- Drives the result SRAM write port.

---
 rtl/lwe_pkg.sv | 20 ++
 rtl/lwe_scale_round.sv | 29 ++
 rtl/lwe_mac_datapath.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lwe_pkg.sv
// rtl/lwe_pkg.sv - shared opcodes, FSM state encoding and delta shift helper for the LWE MAC datapath
package lwe_pkg;

   localparam logic [1:0] OPC_ENCRYPT = 2'd0;
   localparam logic [1:0] OPC_DECRYPT = 2'd1;
   localparam logic [1:0] OPC_ADD     = 2'd2;
   localparam logic [1:0] OPC_MULT    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // delta = 2^(q bits - p bits); expressed as a shift amount
   function automatic int delta_shift(input int ct_width, input int pt_width);
      return ct_width - pt_width;
   endfunction

endpackage

// File: rtl/lwe_scale_round.sv
// rtl/lwe_scale_round.sv - plaintext encode (m*delta) and decode (floor, or round when LWE_DEC_ROUND_EN is defined)
module lwe_scale_round
   import lwe_pkg::*;
#(
   parameter int PLAINTEXT_WIDTH  = 6,
   parameter int CIPHERTEXT_WIDTH = 10
) (
   input  logic [PLAINTEXT_WIDTH-1:0]  msg,
   input  logic [CIPHERTEXT_WIDTH-1:0] x,
   output logic [CIPHERTEXT_WIDTH-1:0] enc_term,
   output logic [PLAINTEXT_WIDTH-1:0]  dec_msg
);

   localparam int SHIFT = delta_shift(CIPHERTEXT_WIDTH, PLAINTEXT_WIDTH);

   assign enc_term = CIPHERTEXT_WIDTH'(msg) << SHIFT;

`ifdef LWE_DEC_ROUND_EN
   localparam logic [CIPHERTEXT_WIDTH-1:0] HALF_DELTA = CIPHERTEXT_WIDTH'(1) << (SHIFT - 1);
   logic [CIPHERTEXT_WIDTH-1:0] x_rnd;

   // wraps mod q first, so values just below q round to plaintext 0
   assign x_rnd   = x + HALF_DELTA;
   assign dec_msg = x_rnd[CIPHERTEXT_WIDTH-1 -: PLAINTEXT_WIDTH];
`else
   assign dec_msg = x[CIPHERTEXT_WIDTH-1 -: PLAINTEXT_WIDTH];
`endif

endmodule

// File: rtl/lwe_mac_datapath.sv
// rtl/lwe_mac_datapath.sv - LWE encrypt/decrypt inner-product MAC and ciphertext add; DEC rounding via LWE_DEC_ROUND_EN
module lwe_mac_datapath
   import lwe_pkg::*;
#(
   parameter int PLAINTEXT_WIDTH  = 6,
   parameter int CIPHERTEXT_WIDTH = 10,
   parameter int DIMENSION        = 10,
   parameter int DIM_WIDTH        = 4,
   parameter int ADDR_WIDTH       = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [1:0]                  opcode,
   input  logic [DIM_WIDTH-1:0]        row,
   input  logic [ADDR_WIDTH-1:0]       out_addr,
   input  logic [CIPHERTEXT_WIDTH-1:0] op1_rdata,
   input  logic [CIPHERTEXT_WIDTH-1:0] op2_rdata,
   input  logic [CIPHERTEXT_WIDTH-1:0] scalar_in,
   input  logic [PLAINTEXT_WIDTH-1:0]  msg_in,
   output logic                        wr_en,
   output logic [ADDR_WIDTH-1:0]       wr_addr,
   output logic [CIPHERTEXT_WIDTH-1:0] wr_data,
   output logic                        done,
   output logic                        err
);

   localparam logic [DIM_WIDTH-1:0] LAST_ROW = DIM_WIDTH'(DIMENSION - 1);

   logic                        s0_valid;
   logic [1:0]                  s0_opc;
   logic [DIM_WIDTH-1:0]        s0_row;
   logic [ADDR_WIDTH-1:0]       s0_addr;
   logic [CIPHERTEXT_WIDTH-1:0] s0_scalar;
   logic [PLAINTEXT_WIDTH-1:0]  s0_msg;

   logic                        s1_valid;
   logic [1:0]                  s1_opc;
   logic [DIM_WIDTH-1:0]        s1_row;
   logic [ADDR_WIDTH-1:0]       s1_addr;
   logic [CIPHERTEXT_WIDTH-1:0] s1_scalar;
   logic [PLAINTEXT_WIDTH-1:0]  s1_msg;
   logic [CIPHERTEXT_WIDTH-1:0] s1_prod;
   logic [CIPHERTEXT_WIDTH-1:0] s1_sum;

   state_t                      state, state_d;
   logic [CIPHERTEXT_WIDTH-1:0] acc, acc_d;
   logic [DIM_WIDTH-1:0]        last_row, last_row_d;
   logic [1:0]                  lat_opc, lat_opc_d;
   logic [CIPHERTEXT_WIDTH-1:0] lat_scalar, lat_scalar_d;
   logic [PLAINTEXT_WIDTH-1:0]  lat_msg, lat_msg_d;
   logic [ADDR_WIDTH-1:0]       lat_addr, lat_addr_d;
   logic                        err_d;

   logic                        s1_legal, s1_add, s1_mac, fin;
   logic [CIPHERTEXT_WIDTH-1:0] dec_x, enc_term;
   logic [PLAINTEXT_WIDTH-1:0]  dec_msg;

   // element pipeline: stage0 captures the request, stage1 the operand arithmetic
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid  <= 1'b0;
         s0_opc    <= '0;
         s0_row    <= '0;
         s0_addr   <= '0;
         s0_scalar <= '0;
         s0_msg    <= '0;
         s1_valid  <= 1'b0;
         s1_opc    <= '0;
         s1_row    <= '0;
         s1_addr   <= '0;
         s1_scalar <= '0;
         s1_msg    <= '0;
         s1_prod   <= '0;
         s1_sum    <= '0;
      end else begin
         s0_valid <= en;
         if (en) begin
            s0_opc    <= opcode;
            s0_row    <= row;
            s0_addr   <= out_addr;
            s0_scalar <= scalar_in;
            s0_msg    <= msg_in;
         end
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_opc    <= s0_opc;
            s1_row    <= s0_row;
            s1_addr   <= s0_addr;
            s1_scalar <= s0_scalar;
            s1_msg    <= s0_msg;
            s1_prod   <= CIPHERTEXT_WIDTH'(op1_rdata * op2_rdata);
            s1_sum    <= op1_rdata + op2_rdata;
         end
      end
   end

   assign s1_legal = s1_valid && (s1_opc != OPC_MULT) && (32'(s1_row) < DIMENSION);
   assign s1_add   = s1_legal && (s1_opc == OPC_ADD);
   assign s1_mac   = s1_legal && ((s1_opc == OPC_ENCRYPT) || (s1_opc == OPC_DECRYPT));
   assign fin      = (state == ST_FINISH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         acc        <= '0;
         last_row   <= '0;
         lat_opc    <= '0;
         lat_scalar <= '0;
         lat_msg    <= '0;
         lat_addr   <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         acc        <= acc_d;
         last_row   <= last_row_d;
         lat_opc    <= lat_opc_d;
         lat_scalar <= lat_scalar_d;
         lat_msg    <= lat_msg_d;
         lat_addr   <= lat_addr_d;
         err        <= err_d;
      end
   end

   always_comb begin
      state_d      = state;
      acc_d        = acc;
      last_row_d   = last_row;
      lat_opc_d    = lat_opc;
      lat_scalar_d = lat_scalar;
      lat_msg_d    = lat_msg;
      lat_addr_d   = lat_addr;
      err_d        = err;

      if (s1_valid && !s1_legal) begin
         err_d = 1'b1;
      end

      // a row-0 element may open a new operation from any state, including the FINISH cycle
      if (s1_mac && (s1_row == '0)) begin
         if (state == ST_ACCUM) begin
            err_d = 1'b1;
         end
         state_d      = (LAST_ROW == '0) ? ST_FINISH : ST_ACCUM;
         acc_d        = s1_prod;
         last_row_d   = '0;
         lat_opc_d    = s1_opc;
         lat_scalar_d = s1_scalar;
         lat_msg_d    = s1_msg;
         lat_addr_d   = s1_addr;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (s1_mac) begin
                  if (s1_row == last_row + DIM_WIDTH'(1)) begin
                     acc_d      = acc + s1_prod;
                     last_row_d = s1_row;
                     if (s1_row == LAST_ROW) begin
                        state_d = ST_FINISH;
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_FINISH: begin
               state_d = ST_IDLE;
               if (s1_add || s1_mac) begin
                  err_d = 1'b1;
               end
            end
            default: begin
               if (s1_mac) begin
                  err_d = 1'b1;
               end
            end
         endcase
      end
   end

   assign dec_x = lat_scalar - acc;

   lwe_scale_round #(
      .PLAINTEXT_WIDTH  (PLAINTEXT_WIDTH),
      .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH)
   ) u_scale_round (
      .msg      (lat_msg),
      .x        (dec_x),
      .enc_term (enc_term),
      .dec_msg  (dec_msg)
   );

   // the FINISH write owns the port; a coincident ADD write is dropped
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      done    = 1'b0;
      if (fin) begin
         wr_en   = 1'b1;
         done    = 1'b1;
         wr_addr = lat_addr;
         if (lat_opc == OPC_DECRYPT) begin
            wr_data = CIPHERTEXT_WIDTH'(dec_msg);
         end else begin
            wr_data = acc + lat_scalar + enc_term;
         end
      end else if (s1_add) begin
         wr_en   = 1'b1;
         wr_addr = s1_addr;
         wr_data = s1_sum;
      end
   end

endmodule
